// File: rtl/alu_ctrl_pkg.sv
// Shared constants, types and helpers for the ALU access controller.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [FUNC_W-1:0] FN_ADD  = 6'd0;
    localparam logic [FUNC_W-1:0] FN_MULS = 6'd2;
    localparam logic [FUNC_W-1:0] FN_NEG  = 6'd3;
    localparam logic [FUNC_W-1:0] FN_AND  = 6'd4;
    localparam logic [FUNC_W-1:0] FN_XOR  = 6'd5;
    localparam logic [FUNC_W-1:0] FN_SLL  = 6'd6;
    localparam logic [FUNC_W-1:0] FN_SRL  = 6'd7;
    localparam logic [FUNC_W-1:0] FN_SLLV = 6'd8;
    localparam logic [FUNC_W-1:0] FN_SRLV = 6'd9;
    localparam logic [FUNC_W-1:0] FN_SRA  = 6'd10;
    localparam logic [FUNC_W-1:0] FN_SRAV = 6'd11;

    localparam int unsigned CARRY = 3;
    localparam int unsigned SIGN  = 2;
    localparam int unsigned OVF   = 1;
    localparam int unsigned ZERO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] res1;
        logic [DATA_W-1:0] res2;
        logic [FLAG_W-1:0] flags;
        logic              err;
    } rsp_t;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        case (f)
            FN_ADD, FN_MULS, FN_NEG, FN_AND, FN_XOR, FN_SLL,
            FN_SRL, FN_SLLV, FN_SRLV, FN_SRA, FN_SRAV: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_access_controller_rr_arbiter2.sv
// Two-port round-robin arbiter; a tie goes to the port not granted last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) grant_o = ptr_q ? 2'b10 : 2'b01;
            else                grant_o = req_i;
        end
        ptr_d = ptr_q;
        // a grant is always taken (ready mirrors grant), so flip on it
        if (|grant_o) ptr_d = grant_o[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_access_controller.sv
// Shares one ALU between two requesters: arbitrate, set up, pulse, wait, respond.
module alu_access_controller
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [FUNC_W-1:0]  req0_func,
    input  logic [FUNC_W-1:0]  req1_func,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_res1,
    output logic [DATA_W-1:0]  rsp_res2,
    output logic [FLAG_W-1:0]  rsp_flags,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  alu_inp1,
    output logic [DATA_W-1:0]  alu_inp2,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [FUNC_W-1:0]  alu_func,
    output logic               alu_ena,
    input  logic [DATA_W-1:0]  alu_res1,
    input  logic [DATA_W-1:0]  alu_res2,
    input  logic               alu_carry,
    input  logic               alu_sign,
    input  logic               alu_ovf,
    input  logic               alu_zero,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    rsp_t                rsp_q, rsp_d;
    logic                ena_q, valid_q, busy_q, idle_q;
    logic [1:0]          grant;
    logic                sel_id;
    logic [FUNC_W-1:0]   sel_func;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [SHAMT_W-1:0]  sel_shamt;

    // idle_q resets low, so no port sees ready while rst_n is asserted
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   ({req1_valid, req0_valid}),
        .en_i    (idle_q),
        .grant_o (grant)
    );

    assign sel_id    = grant[1];
    assign sel_func  = sel_id ? req1_func  : req0_func;
    assign sel_a     = sel_id ? req1_a     : req0_a;
    assign sel_b     = sel_id ? req1_b     : req0_b;
    assign sel_shamt = sel_id ? req1_shamt : req0_shamt;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        shamt_d = shamt_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    func_d   = sel_func;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    shamt_d  = sel_shamt;
                    rsp_d    = '0;
                    rsp_d.id = sel_id;
                    if (func_legal(sel_func)) begin
                        state_d = ST_SETUP;
                    end else begin
                        rsp_d.err = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: begin
                cnt_d   = (func_q == FN_MULS) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    rsp_d.res1         = alu_res1;
                    rsp_d.res2         = alu_res2;
                    rsp_d.flags[CARRY] = alu_carry;
                    rsp_d.flags[SIGN]  = alu_sign;
                    rsp_d.flags[OVF]   = alu_ovf;
                    rsp_d.flags[ZERO]  = alu_zero;
                    cnt_d              = '0;
                    state_d            = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // datapath and registered status outputs follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shamt_q <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
            ena_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shamt_q <= shamt_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            ena_q   <= (state_d == ST_PULSE);
            valid_q <= (state_d == ST_RESP);
            busy_q  <= (state_d != ST_IDLE);
            idle_q  <= (state_d == ST_IDLE);
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = valid_q;
    assign rsp_id     = rsp_q.id;
    assign rsp_res1   = rsp_q.res1;
    assign rsp_res2   = rsp_q.res2;
    assign rsp_flags  = rsp_q.flags;
    assign rsp_err    = rsp_q.err;
    assign alu_inp1   = a_q;
    assign alu_inp2   = b_q;
    assign alu_shamt  = shamt_q;
    assign alu_func   = func_q;
    assign alu_ena    = ena_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_access_controller.sv
// Random + directed scoreboard bench for alu_access_controller with an ALU stand-in.
module tb_alu_access_controller;
    import alu_ctrl_pkg::*;

    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned MUL_LAT = 3;

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
    } op_t;

    typedef struct packed {
        logic [31:0] res1;
        logic [31:0] res2;
        logic [3:0]  flags;
    } alu_out_t;

    typedef struct {
        logic        id;
        logic [31:0] res1;
        logic [31:0] res2;
        logic [3:0]  flags;
        logic        err;
        int          t;
        int          due;
        int          ena0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0;
    op_t  cur0 = '0, cur1 = '0;
    logic rsp_ready = 1'b0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_ena, busy;
    logic [31:0] rsp_res1, rsp_res2, alu_inp1, alu_inp2;
    logic [3:0]  rsp_flags;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_func;
    alu_out_t stub_o = '0, stub_r = '0;
    logic stub_ena_q = 1'b0;
    int   stub_cd = 0;

    int   vectors = 0, miscompares = 0, cyc = 0;
    op_t  q0[$], q1[$];
    exp_t sb[$];
    logic id_log[$];
    logic acc0 = 1'b0, acc1 = 1'b0, model_busy = 1'b0, done_pend = 1'b0;
    logic in_rsp = 1'b0, last_gnt = 1'b1, ena_prev = 1'b0;
    logic [71:0] snap;
    int   ena_cnt = 0, ena_cyc = 0, rsp_mode = 0;
    logic [31:0] last_res1, last_res2;
    logic [3:0]  last_flags;
    logic        last_err;
    int          last_lat;

    alu_access_controller #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req1_valid(v1), .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_func(cur0.func), .req1_func(cur1.func), .req0_a(cur0.a), .req1_a(cur1.a),
        .req0_b(cur0.b), .req1_b(cur1.b), .req0_shamt(cur0.shamt), .req1_shamt(cur1.shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res1(rsp_res1), .rsp_res2(rsp_res2), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_shamt(alu_shamt), .alu_func(alu_func),
        .alu_ena(alu_ena), .alu_res1(stub_o.res1), .alu_res2(stub_o.res2),
        .alu_carry(stub_o.flags[CARRY]), .alu_sign(stub_o.flags[SIGN]),
        .alu_ovf(stub_o.flags[OVF]), .alu_zero(stub_o.flags[ZERO]), .busy(busy)
    );

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural ALU used both by the stand-in and the expected-value model
    function automatic alu_out_t alu_ref(input op_t op);
        alu_out_t r;
        logic [32:0] s;
        logic signed [63:0] p;
        r = '0;
        case (op.func)
            FN_ADD: begin
                s = {1'b0, op.a} + {1'b0, op.b};
                r.res1 = s[31:0];
                r.flags[CARRY] = s[32];
                r.flags[OVF] = (op.a[31] == op.b[31]) && (s[31] != op.a[31]);
            end
            FN_MULS: begin
                p = $signed(op.a) * $signed(op.b);
                r.res1 = p[63:32];
                r.res2 = p[31:0];
            end
            FN_NEG:  r.res1 = 32'd0 - op.a;
            FN_AND:  r.res1 = op.a & op.b;
            FN_XOR:  r.res1 = op.a ^ op.b;
            FN_SLL:  r.res1 = op.a << op.shamt;
            FN_SRL:  r.res1 = op.a >> op.shamt;
            FN_SLLV: r.res1 = op.a << op.b[4:0];
            FN_SRLV: r.res1 = op.a >> op.b[4:0];
            FN_SRA:  r.res1 = $unsigned($signed(op.a) >>> op.shamt);
            FN_SRAV: r.res1 = $unsigned($signed(op.a) >>> op.b[4:0]);
            default: r.res1 = '0;
        endcase
        r.flags[SIGN] = r.res1[31];
        r.flags[ZERO] = (r.res1 == 32'd0);
        return r;
    endfunction

    function automatic int lat_of(input logic [5:0] f);
        return (f == FN_MULS) ? int'(MUL_LAT) : int'(ALU_LAT);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op(input bit legal_only);
        op_t o;
        int k;
        k = $urandom_range(0, 11);
        if (!legal_only && $urandom_range(0, 7) == 0)
            o.func = ($urandom_range(0, 3) == 0) ? 6'd1 : 6'($urandom_range(12, 63));
        else
            o.func = (k == 1) ? FN_ADD : 6'(k);
        o.a = pick();
        o.b = pick();
        o.shamt = 5'($urandom);
        return o;
    endfunction

    // ALU stand-in: result valid only from lat-1 edges after the enable edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_ena_q <= 1'b0;
            stub_cd <= 0;
            stub_o <= '0;
        end else begin
            stub_ena_q <= alu_ena;
            if (alu_ena && !stub_ena_q) begin
                stub_r <= alu_ref({alu_func, alu_inp1, alu_inp2, alu_shamt});
                if (lat_of(alu_func) <= 1) stub_o <= alu_ref({alu_func, alu_inp1, alu_inp2, alu_shamt});
                else stub_o <= {$urandom, $urandom, 4'($urandom)};
                stub_cd <= lat_of(alu_func) - 1;
            end else if (stub_cd == 1) begin
                stub_o <= stub_r;
                stub_cd <= 0;
            end else if (stub_cd > 1) begin
                stub_cd <= stub_cd - 1;
            end
        end
    end

    // requester drivers and response-ready driver
    initial forever begin
        @(posedge clk);
        #1;
        if (acc0) begin v0 = 1'b0; acc0 = 1'b0; end
        if (acc1) begin v1 = 1'b0; acc1 = 1'b0; end
        if (rst_n && !v0 && q0.size() > 0) begin cur0 = q0.pop_front(); v0 = 1'b1; end
        if (rst_n && !v1 && q1.size() > 0) begin cur1 = q1.pop_front(); v1 = 1'b1; end
        if (rsp_mode != 0) rsp_ready = 1'($urandom_range(0, 1));
    end

    // monitor: grant model, enable pulse tracking, response scoreboard
    initial forever begin
        logic [1:0] exp_rdy;
        op_t        op;
        alu_out_t   r;
        exp_t       e;
        @(negedge clk);
        if (rst_n) begin
            if (done_pend) begin model_busy = 1'b0; done_pend = 1'b0; end
            chk("busy", 72'(busy), 72'(model_busy));
            if (!model_busy && (v0 || v1))
                exp_rdy = (v0 && v1) ? (last_gnt ? 2'b01 : 2'b10) : {v1, v0};
            else
                exp_rdy = 2'b00;
            chk("grant", 72'({req1_ready, req0_ready}), 72'(exp_rdy));
            if ((v0 && req0_ready) || (v1 && req1_ready)) begin
                e.id = !(v0 && req0_ready);
                op = e.id ? cur1 : cur0;
                if (op.func == 6'd0 || (op.func >= 6'd2 && op.func <= 6'd11)) begin
                    r = alu_ref(op);
                    e.res1 = r.res1; e.res2 = r.res2; e.flags = r.flags; e.err = 1'b0;
                    e.due = 3 + lat_of(op.func);
                end else begin
                    e.res1 = '0; e.res2 = '0; e.flags = '0; e.err = 1'b1; e.due = 1;
                end
                e.t = cyc;
                e.ena0 = ena_cnt;
                sb.push_back(e);
                model_busy = 1'b1;
                last_gnt = e.id;
                if (e.id) acc1 = 1'b1; else acc0 = 1'b1;
            end
            if (alu_ena) begin
                chk("ena_width", 72'(ena_prev), 72'(0));
                if (!ena_prev) begin ena_cnt++; ena_cyc = cyc; end
            end
            ena_prev = alu_ena;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        chk("rsp_without_request", 72'(sb.size()), 72'(1));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 72'(rsp_id), 72'(e.id));
                        chk("rsp_res1", 72'(rsp_res1), 72'(e.res1));
                        chk("rsp_res2", 72'(rsp_res2), 72'(e.res2));
                        chk("rsp_flags", 72'(rsp_flags), 72'(e.flags));
                        chk("rsp_err", 72'(rsp_err), 72'(e.err));
                        chk("rsp_latency", 72'(cyc - e.t), 72'(e.due));
                        chk("ena_pulses", 72'(ena_cnt - e.ena0), e.err ? 72'(0) : 72'(1));
                        if (!e.err) chk("ena_cycle", 72'(ena_cyc - e.t), 72'(2));
                        last_res1 = rsp_res1; last_res2 = rsp_res2;
                        last_flags = rsp_flags; last_err = rsp_err; last_lat = cyc - e.t;
                        id_log.push_back(rsp_id);
                    end
                    snap = {31'd0, rsp_id, rsp_res1, rsp_res2, rsp_flags, rsp_err};
                    in_rsp = 1'b1;
                end else begin
                    chk("rsp_hold", {31'd0, rsp_id, rsp_res1, rsp_res2, rsp_flags, rsp_err}, snap);
                end
                if (rsp_ready) begin in_rsp = 1'b0; done_pend = 1'b1; end
            end else if (in_rsp) begin
                chk("rsp_dropped", 72'(rsp_valid), 72'(1));
                in_rsp = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || sb.size() > 0 || model_busy) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", 72'(n >= maxc), 72'(0));
        repeat (2) @(posedge clk);
    endtask

    task automatic flush_model();
        sb.delete(); q0.delete(); q1.delete();
        v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        model_busy = 1'b0; done_pend = 1'b0; in_rsp = 1'b0;
        last_gnt = 1'b1; ena_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req0_ready", 72'(req0_ready), 72'(0));
        chk("rst_req1_ready", 72'(req1_ready), 72'(0));
        chk("rst_alu_ena", 72'(alu_ena), 72'(0));
        chk("rst_rsp_valid", 72'(rsp_valid), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_outputs", {rsp_res1, rsp_res2, 8'(rsp_flags)}, 72'(0));
        chk("rst_alu_regs", {alu_inp1, alu_inp2, 8'(alu_func)}, 72'(0));
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        rsp_ready = 1'b1;

        q0.push_back('{FN_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0});
        wait_idle(200);
        chk("add_res1", 72'(last_res1), 72'(32'h8000_0000));
        chk("add_flags", 72'(last_flags), 72'(4'b0110));
        chk("add_latency", 72'(last_lat), 72'(4));

        q1.push_back('{FN_MULS, 32'hFFFF_FFFE, 32'd3, 5'd0});
        wait_idle(200);
        chk("mul_res1", 72'(last_res1), 72'(32'hFFFF_FFFF));
        chk("mul_res2", 72'(last_res2), 72'(32'hFFFF_FFFA));
        chk("mul_sign", 72'(last_flags[SIGN]), 72'(1));
        chk("mul_latency", 72'(last_lat), 72'(6));

        id_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op(1'b1));
            q1.push_back(rand_op(1'b1));
        end
        wait_idle(500);
        chk("rr_count", 72'(id_log.size()), 72'(8));
        for (int i = 0; i < id_log.size(); i++) chk("rr_order", 72'(id_log[i]), 72'(i % 2));

        q0.push_back('{6'd1, 32'h1234_5678, 32'h9, 5'd3});
        wait_idle(200);
        chk("illegal_err", 72'(last_err), 72'(1));
        chk("illegal_latency", 72'(last_lat), 72'(1));

        @(posedge clk); #1 rsp_ready = 1'b0;
        q0.push_back(rand_op(1'b1));
        q1.push_back(rand_op(1'b1));
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("stall_busy", 72'(busy), 72'(1));
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle(300);

        rsp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) q1.push_back(rand_op(1'b0));
            else q0.push_back(rand_op(1'b0));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(5000);
        rsp_mode = 0;
        @(posedge clk); #1 rsp_ready = 1'b1;

        q1.push_back('{FN_MULS, 32'h0000_1234, 32'hFFFF_0001, 5'd0});
        for (int i = 0; i < 100 && !alu_ena; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        flush_model();
        #1;
        chk("midrst_alu_ena", 72'(alu_ena), 72'(0));
        chk("midrst_rsp_valid", 72'(rsp_valid), 72'(0));
        chk("midrst_busy", 72'(busy), 72'(0));
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        q0.push_back(rand_op(1'b1));
        q1.push_back(rand_op(1'b1));
        id_log.delete();
        wait_idle(300);
        chk("post_rst_count", 72'(id_log.size()), 72'(2));
        if (id_log.size() > 0) chk("post_rst_tie", 72'(id_log[0]), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_access_controller.md
Name: alu_access_controller

Overview:
- Sequences and shares the single ALU_unit datapath between two requesters: port 0 (integer pipe) and port 1 (address/branch unit).
- Arbitrates round-robin, registers operands, and generates the rising-edge enable pulse the ALU triggers on.
- Waits a per-function latency, captures res1/res2/flags, and returns them on a valid/ready response channel tagged with the requester id.
- Sits between the decode/issue stage and ALU_unit; it is the only driver of the ALU inputs.

Parameters:
- ALU_LAT, 1, wait cycles after the enable pulse for funcs 0 and 3-11 (minimum 1).
- MUL_LAT, 3, wait cycles after the enable pulse for func 2, signed multiply (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_func / req1_func  in  6  ALU function code.
- req0_a / req1_a  in  32  operand 1.
- req0_b / req1_b  in  32  operand 2.
- req0_shamt / req1_shamt  in  5  shift amount.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  originating requester.
- rsp_res1  out  32  low result; high product word for func 2.
- rsp_res2  out  32  second result; low product word for func 2, 0 otherwise.
- rsp_flags  out  4  {carry, sign, overflow, zero}.
- rsp_err  out  1  unsupported func.
- alu_inp1 / alu_inp2  out  32  to ALU.
- alu_shamt  out  5  to ALU.
- alu_func  out  6  to ALU.
- alu_ena  out  1  to ALU; a rising edge starts the operation.
- alu_res1 / alu_res2  in  32  from ALU.
- alu_carry, alu_sign, alu_ovf, alu_zero  in  1  from ALU.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n is low, all outputs are 0, state is IDLE, the round-robin pointer is 0, and the wait counter is 0.
- Reset mid-operation: alu_ena drops immediately, the in-flight op and any pending response are discarded, and no rsp_valid follows.
- States: IDLE -> SETUP -> PULSE -> WAIT -> RESP -> IDLE. Illegal func: IDLE -> RESP.
- IDLE:
  - reqN_ready is high only for the granted port, and only in IDLE.
  - Grant rule: if only one port is valid, that port wins. If both are valid, the port other than the last granted wins. After reset, port 0 wins a tie.
  - The accept cycle T is the cycle in which the granted port has valid and ready both high.
  - In cycle T the block latches func/a/b/shamt/id into alu_* registers and flips the pointer.
  - ready is never high on both ports in the same cycle.
- Func check: legal funcs are 0 and 2-11. On 1 or 12-63, go to RESP with rsp_err=1, res1=res2=0, flags=0. rsp_valid is high at T+1 and alu_ena never pulses.
- SETUP (T+1): alu_* operands are stable and alu_ena=0. This guarantees operand setup before the enable edge.
- PULSE (T+2): alu_ena=1 for exactly one cycle. The counter loads MUL_LAT if func==2, else ALU_LAT.
- WAIT:
  - alu_ena=0; decrement the counter each cycle.
  - When the counter reaches 1, capture alu_res1, alu_res2 and flags into the rsp_* registers and enter RESP.
  - The alu_* operand outputs hold their values through WAIT.
- RESP:
  - rsp_valid=1, first at T+3+lat (lat = ALU_LAT or MUL_LAT).
  - rsp_* outputs hold stable until rsp_valid and rsp_ready are both high, then go to IDLE.
  - No new request is accepted while in RESP, so back-to-back throughput is 1 op per (4+lat) cycles when rsp_ready is held high.
- Requests arriving during busy stay pending; the requester must hold its valid and payload stable until ready.
- The block does not interpret results; flags pass through unmodified.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - Function code constants: FN_ADD=0, FN_MULS=2, FN_NEG=3, FN_AND=4, FN_XOR=5, FN_SLL=6, FN_SRL=7, FN_SLLV=8, FN_SRLV=9, FN_SRA=10, FN_SRAV=11.
  - Legal-func predicate.
  - State encoding.
  - Flag bit indices: CARRY=3, SIGN=2, OVF=1, ZERO=0.
- One natural sub-module, rr_arbiter2: two requests, enable, pointer update on accept, one-hot grant.

Test Plan:
- Reset, then req0 func=0 a=0x7FFFFFFF b=1, rsp_ready=1 -> ready at T, alu_ena high only at T+2, rsp_valid at T+4, id=0, res1=0x80000000, flags sign=1 ovf=1 carry=0 zero=0.
- req1 func=2 a=0xFFFFFFFE b=3, MUL_LAT=3 -> rsp_valid at T+6, res1=0xFFFFFFFF, res2=0xFFFFFFFA, sign=1.
- Both ports valid continuously, 4 ops each -> grants 0,1,0,1,... with rsp_id matching; no lost or duplicated op; second grant no earlier than the first RESP handshake.
- req0 func=1 -> rsp_valid at T+1, rsp_err=1, res1=0, alu_ena stays 0 throughout.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, reqN_ready stays 0, busy=1; rsp_ready=1 -> IDLE the next cycle.
- Assert rst_n=0 during WAIT of a multiply -> alu_ena, rsp_valid and busy are 0 asynchronously; after release, a new op completes normally with port 0 winning a tie.
